// File: rtl/div_issue_ctrl.sv
// Issue controller for a fixed-latency divider: arbitrates two requesters, tracks in-flight ops with a
// shadow valid chain and buffers completions in a credit-protected FIFO. Macro DIV_RR_ARB_EN selects
// round-robin arbitration; without it requester 0 always has priority.
module div_issue_ctrl #(
    parameter int LAT   = 32,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req0_A,
    input  logic [31:0] req1_A,
    input  logic [31:0] req0_B,
    input  logic [31:0] req1_B,
    input  logic [6:0]  req0_pa,
    input  logic [6:0]  req1_pa,
    input  logic [31:0] req0_pc,
    input  logic [31:0] req1_pc,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic [1:0]  req_grant,
    input  logic        flush,
    output logic        div_start,
    output logic [31:0] div_A,
    output logic [31:0] div_B,
    output logic [31:0] div_pc,
    output logic [6:0]  div_pa,
    output logic [3:0]  div_op,
    input  logic [31:0] div_result,
    input  logic [6:0]  div_pa_in,
    input  logic [31:0] div_pc_in,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [6:0]  out_pa,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        busy
);
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int ICW = $clog2(LAT + 1);
    localparam int SW  = ((ICW > FCW) ? ICW : FCW) + 1;
    localparam int EW  = 32 + 7 + 32;

    logic [LAT-1:0] shadow_reg, shadow_next;
    logic [ICW-1:0] inflight_reg, inflight_next;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [FCW-1:0] fifo_count_reg, fifo_count_next;
    logic [EW-1:0]  fifo_mem [DEPTH];
    logic [EW-1:0]  head;
    logic [1:0]     grant_raw;
    logic           credit_ok, push, pop, fifo_empty, exit_valid;

    // Every granted op owns a FIFO slot from issue until it is popped, so a push can never overflow.
    assign credit_ok = (SW'(inflight_reg) + SW'(fifo_count_reg)) < SW'(DEPTH);

`ifdef DIV_RR_ARB_EN
    logic rr_ptr_reg, rr_ptr_next;

    always_comb begin
        grant_raw = req_valid;
        if (req_valid == 2'b11) grant_raw = rr_ptr_reg ? 2'b10 : 2'b01;
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (div_start) rr_ptr_next = req_grant[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr_reg <= 1'b0;
        else        rr_ptr_reg <= rr_ptr_next;
    end
`else
    always_comb begin
        grant_raw = req_valid;
        if (req_valid[0]) grant_raw = 2'b01;
    end
`endif

    assign req_grant = (credit_ok && !flush && reset) ? grant_raw : 2'b00;
    assign div_start = |req_grant;
    assign div_A     = req_grant[1] ? req1_A  : req0_A;
    assign div_B     = req_grant[1] ? req1_B  : req0_B;
    assign div_pa    = req_grant[1] ? req1_pa : req0_pa;
    assign div_pc    = req_grant[1] ? req1_pc : req0_pc;
    assign div_op    = req_grant[1] ? req1_op : req0_op;

    assign exit_valid = shadow_reg[LAT-1];
    assign fifo_empty = (fifo_count_reg == '0);
    assign push       = exit_valid && !flush;
    assign pop        = !fifo_empty && out_ready && !flush;

    always_comb begin
        shadow_next     = (shadow_reg << 1) | LAT'(div_start);
        inflight_next   = inflight_reg + ICW'(div_start) - ICW'(exit_valid);
        wr_ptr_next     = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next     = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        fifo_count_next = fifo_count_reg + FCW'(push) - FCW'(pop);
        if (flush) begin
            shadow_next     = '0;
            inflight_next   = '0;
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            fifo_count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_reg     <= '0;
            inflight_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            shadow_reg     <= shadow_next;
            inflight_reg   <= inflight_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            fifo_count_reg <= fifo_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= {div_result, div_pa_in, div_pc_in};
    end

    // Head is zeroed when empty so the completion bus reads 0 out of reset.
    assign head       = fifo_mem[rd_ptr_reg];
    assign out_valid  = !fifo_empty;
    assign out_result = out_valid ? head[EW-1 -: 32] : '0;
    assign out_pa     = out_valid ? head[38:32]      : '0;
    assign out_pc     = out_valid ? head[31:0]       : '0;
    assign busy       = (inflight_reg != '0) || !fifo_empty;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency divider model; expected grant order
// follows the DIV_RR_ARB_EN build option.
module tb_div_issue_ctrl;
    localparam int LAT   = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [31:0] req0_A = '0, req1_A = '0, req0_B = '0, req1_B = '0;
    logic [6:0]  req0_pa = '0, req1_pa = '0;
    logic [31:0] req0_pc = '0, req1_pc = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [1:0]  req_grant;
    logic        flush = 1'b0;
    logic        div_start;
    logic [31:0] div_A, div_B, div_pc;
    logic [6:0]  div_pa;
    logic [3:0]  div_op;
    logic [31:0] div_result;
    logic [6:0]  div_pa_in;
    logic [31:0] div_pc_in;
    logic        out_valid;
    logic [31:0] out_result;
    logic [6:0]  out_pa;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req0_A(req0_A), .req1_A(req1_A), .req0_B(req0_B), .req1_B(req1_B),
        .req0_pa(req0_pa), .req1_pa(req1_pa), .req0_pc(req0_pc), .req1_pc(req1_pc),
        .req0_op(req0_op), .req1_op(req1_op), .req_grant(req_grant), .flush(flush),
        .div_start(div_start), .div_A(div_A), .div_B(div_B), .div_pc(div_pc),
        .div_pa(div_pa), .div_op(div_op), .div_result(div_result),
        .div_pa_in(div_pa_in), .div_pc_in(div_pc_in), .out_valid(out_valid),
        .out_result(out_result), .out_pa(out_pa), .out_pc(out_pc),
        .out_ready(out_ready), .busy(busy)
    );

    // Divider model: result appears LAT cycles after the sampling edge; garbage otherwise.
    logic [LAT-1:0] dv_v;
    logic [31:0]    dv_res [LAT];
    logic [6:0]     dv_pa  [LAT];
    logic [31:0]    dv_pc  [LAT];

    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        if (op == 4'b0010) return (b == 32'd0) ? a : a % b;
        return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_v <= '0;
        end else begin
            dv_v <= {dv_v[LAT-2:0], div_start};
            for (int i = LAT - 1; i > 0; i--) begin
                dv_res[i] <= dv_res[i-1];
                dv_pa[i]  <= dv_pa[i-1];
                dv_pc[i]  <= dv_pc[i-1];
            end
            dv_res[0] <= div_model(div_A, div_B, div_op);
            dv_pa[0]  <= div_pa;
            dv_pc[0]  <= div_pc;
        end
    end

    assign div_result = dv_v[LAT-1] ? dv_res[LAT-1] : 32'hDEAD_BEEF;
    assign div_pa_in  = dv_v[LAT-1] ? dv_pa[LAT-1]  : 7'h7F;
    assign div_pc_in  = dv_v[LAT-1] ? dv_pc[LAT-1]  : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic [6:0] pa, input logic [31:0] pc);
        if (r == 0) begin
            req0_A = a; req0_B = b; req0_op = op; req0_pa = pa; req0_pc = pc;
        end else begin
            req1_A = a; req1_B = b; req1_op = op; req1_pa = pa; req1_pc = pc;
        end
    endtask

    // Idles inputs each cycle until out_valid is seen or max cycles elapse.
    task automatic wait_out(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            req_valid = 2'b00;
            flush = 1'b0;
            #1;
            n++;
        end while (!out_valid && n < max_cyc);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 4 * LAT) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_g [4];
        int n;
        int idx;

        // Reset values with requests pending.
        req_valid = 2'b11;
        @(negedge clk); #1;
        check("rst_grant", 32'(req_grant), 32'd0);
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;

        // Contention from a fresh round-robin pointer.
`ifdef DIV_RR_ARB_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        drive_req(0, 32'd50, 32'd5, 4'b0001, 7'h10, 32'h0000_0100);
        drive_req(1, 32'd81, 32'd9, 4'b0001, 7'h11, 32'h0000_0200);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 2'b11;
            #1;
            check($sformatf("cont_grant%0d", i), 32'(req_grant), 32'(exp_g[i]));
            check($sformatf("cont_div_pa%0d", i), 32'(div_pa), exp_g[i][1] ? 32'h11 : 32'h10);
        end
        wait_out(LAT + 4, n);
        check("cont_first_out", 32'(n), 32'(LAT - 2));
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            check($sformatf("cont_out_pa%0d", i), 32'(out_pa), exp_g[i][1] ? 32'h11 : 32'h10);
            check($sformatf("cont_out_res%0d", i), out_result, exp_g[i][1] ? 32'd9 : 32'd10);
        end
        wait_idle("cont_idle");

        // Single op: 100 / 7.
        @(negedge clk);
        drive_req(0, 32'd100, 32'd7, 4'b0001, 7'h2A, 32'h0000_4000);
        req_valid = 2'b01;
        #1;
        check("single_grant", 32'(req_grant), 32'b01);
        check("single_start", 32'(div_start), 32'd1);
        check("single_div_A", div_A, 32'd100);
        wait_out(LAT + 4, n);
        check("single_latency", 32'(n), 32'(LAT + 1));
        check("single_result", out_result, 32'd14);
        check("single_pa", 32'(out_pa), 32'h2A);
        check("single_pc", out_pc, 32'h0000_4000);
        wait_idle("single_idle");

        // Divide by zero: quotient then remainder.
        @(negedge clk);
        drive_req(0, 32'h1234_5678, 32'd0, 4'b0001, 7'h01, 32'h0000_0010);
        req_valid = 2'b01;
        #1;
        check("dz_grant0", 32'(req_grant), 32'b01);
        @(negedge clk);
        drive_req(0, 32'h1234_5678, 32'd0, 4'b0010, 7'h02, 32'h0000_0014);
        #1;
        check("dz_grant1", 32'(req_grant), 32'b01);
        wait_out(LAT + 4, n);
        check("dz_latency", 32'(n), 32'(LAT));
        check("dz_quot", out_result, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        check("dz_rem", out_result, 32'h1234_5678);
        check("dz_rem_pa", 32'(out_pa), 32'h02);
        wait_idle("dz_idle");

        // Backpressure: only DEPTH grants while the FIFO cannot drain.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < LAT + DEPTH + 8; c++) begin
            @(negedge clk);
            drive_req(0, 32'(1000 + idx * 7), 32'd3, 4'b0001, 7'(idx), 32'(32'h3000 + idx));
            req_valid = 2'b01;
            #1;
            if (req_grant[0]) idx++;
        end
        check("bp_grants", 32'(idx), 32'(DEPTH));
        check("bp_nogrant", 32'(req_grant), 32'd0);
        check("bp_head_valid", 32'(out_valid), 32'd1);
        check("bp_head_pa", 32'(out_pa), 32'd0);
        @(negedge clk); #1;
        check("bp_hold_pa", 32'(out_pa), 32'd0);
        check("bp_hold_res", out_result, 32'd333);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive_req(0, 32'(1000 + idx * 7), 32'd3, 4'b0001, 7'(idx), 32'(32'h3000 + idx));
            req_valid = (idx == DEPTH) ? 2'b01 : 2'b00;
            #1;
            check($sformatf("bp_drain_pa%0d", k), 32'(out_pa), 32'(k));
            check($sformatf("bp_drain_res%0d", k), out_result, 32'((1000 + k * 7) / 3));
            if (req_grant[0]) idx++;
        end
        check("bp_resume", 32'(idx), 32'(DEPTH + 1));
        wait_out(LAT + 4, n);
        check("bp_late_pa", 32'(out_pa), 32'(DEPTH));
        check("bp_late_res", out_result, 32'((1000 + DEPTH * 7) / 3));
        wait_idle("bp_idle");

        // Flush: 5 ops squashed at cycle 10, op at cycle 11 survives.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_req(0, 32'(200 + i), 32'd4, 4'b0001, 7'(32'h20 + i), 32'(32'h2000 + i));
            req_valid = 2'b01;
            #1;
            check($sformatf("fl_grant%0d", i), 32'(req_grant), 32'b01);
        end
        for (int c = 5; c < 10; c++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        drive_req(0, 32'd300, 32'd6, 4'b0001, 7'h55, 32'h0000_5500);
        req_valid = 2'b01;
        #1;
        check("fl_nogrant", 32'(req_grant), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_regrant", 32'(req_grant), 32'b01);
        wait_out(LAT + 6, n);
        check("fl_latency", 32'(n), 32'(LAT + 1));
        check("fl_pa", 32'(out_pa), 32'h55);
        check("fl_res", out_result, 32'd50);
        wait_idle("fl_idle");

        // Reset at cycle 15 with 3 ops in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_req(0, 32'(90 + i), 32'd2, 4'b0001, 7'(32'h30 + i), 32'(32'h6000 + i));
            req_valid = 2'b01;
            #1;
        end
        for (int c = 3; c < 15; c++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
        end
        check("rm_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 2'b01;
        #1;
        check("rm_grant", 32'(req_grant), 32'd0);
        check("rm_start", 32'(div_start), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_out_valid", 32'(out_valid), 32'd0);
        check("rm_out_pa", 32'(out_pa), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b00;
        wait_out(LAT + 8, n);
        check("rm_no_stale", 32'(out_valid), 32'd0);
        check("rm_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
